// File: rtl/const_div_iter_if.sv
// Valid/ready bus for const_div_iter: a dividend goes in, a quotient/remainder pair comes out.
// The remainder width is derived from the divisor exactly as in the divider itself.
interface const_div_iter_if #(
    parameter int WIDTH   = 64,
    parameter int DIVISOR = 5
);
    localparam int RW = $clog2(DIVISOR);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [RW-1:0]    out_r;

    // Producer/consumer view: offers dividends, accepts results.
    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_q, out_r
    );

    // Divider view.
    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_q, out_r
    );
endinterface

// File: rtl/const_div_iter.sv
// Iterative divide-by-constant unit. The dividend is consumed CHUNK bits per cycle,
// MSB first, using the schoolbook remainder recurrence:
//   t = r * 2**CHUNK + next_chunk;  r' = t % DIVISOR;  next quotient digit = t / DIVISOR.
// Because r < DIVISOR, every quotient digit fits in CHUNK bits, so the quotient is
// assembled by shifting digits in from the right. Both divisions are by a constant
// over a narrow (RW+CHUNK)-bit operand.
// IDLE accepts a dividend, RUN performs WIDTH/CHUNK steps, DONE holds the result until
// the consumer takes it. abort returns the unit to IDLE from any state and takes
// priority over both handshakes.
module const_div_iter #(
    parameter int WIDTH   = 64,
    parameter int DIVISOR = 5,
    parameter int CHUNK   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    const_div_iter_if.slave       bus,
    output logic                  busy
);

    localparam int RW    = $clog2(DIVISOR);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int TW    = RW + CHUNK;

    // The divisor is held at recurrence width. A power-of-two divisor still fits,
    // because TW is at least RW+1.
    localparam logic [TW-1:0] DIV_T     = TW'(DIVISOR);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH)) begin : g_bad_chunk_range
            $error("const_div_iter: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
        end
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk_div
            $error("const_div_iter: WIDTH must be a multiple of CHUNK");
        end
        if ((DIVISOR < 2) || (DIVISOR >= 65536)) begin : g_bad_divisor
            $error("const_div_iter: DIVISOR must satisfy 2 <= DIVISOR < 2**16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [TW-1:0]    t_s;
    logic [RW-1:0]    rem_s;
    logic [CHUNK-1:0] digit_s;

    // State, datapath and handshake flags; asynchronous active-low reset to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sh_q        <= {WIDTH{1'b0}};
            q_q         <= {WIDTH{1'b0}};
            r_q         <= {RW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            q_q         <= q_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: abort wins over everything; otherwise accept, iterate, hand off.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // One recurrence step on the datapath, plus output flags decoded from the next state.
    always_comb begin
        sh_d    = sh_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        t_s     = {r_q, sh_q[WIDTH-1 -: CHUNK]};
        rem_s   = RW'(t_s % DIV_T);
        digit_s = CHUNK'(t_s / DIV_T);
        if (abort) begin
            // The in-flight operation is dropped. The last quotient and remainder stay visible
            // but are meaningless while out_valid is low.
            cnt_d = {CW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sh_d  = bus.in_x;
                        q_d   = {WIDTH{1'b0}};
                        r_d   = {RW{1'b0}};
                        cnt_d = {CW{1'b0}};
                    end else begin
                        sh_d = sh_q;
                    end
                end
                S_RUN: begin
                    // Shifting by CHUNK == WIDTH clears the register, which covers the single-step case.
                    sh_d  = sh_q << CHUNK;
                    q_d   = (q_q << CHUNK) | WIDTH'(digit_s);
                    r_d   = rem_s;
                    cnt_d = cnt_q + CW'(1);
                end
                S_DONE: begin
                    q_d = q_q;
                end
                default: begin
                    cnt_d = {CW{1'b0}};
                end
            endcase
        end
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_q     = q_q;
    assign bus.out_r     = r_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_const_div_iter.sv
// Self-checking bench for const_div_iter at its default parameters.
// The driver issues directed and random operations. A negedge monitor keeps a queue of
// expected results, computed with plain 64-bit division and modulo, and checks the
// handshake flags, latency and result values every cycle.
module tb_const_div_iter;

    localparam int WIDTH   = 64;
    localparam int DIVISOR = 5;
    localparam int CHUNK   = 4;
    localparam int STEPS   = WIDTH / CHUNK;
    localparam int RW      = $clog2(DIVISOR);

    logic clk = 1'b0;
    logic rst_n;
    logic abort;
    logic busy;

    const_div_iter_if #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) bus();

    const_div_iter #(.WIDTH(WIDTH), .DIVISOR(DIVISOR), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (abort),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [RW-1:0]    r;
        int               acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Cycle counter: the number of rising edges seen so far.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor and scoreboard. The model is busy exactly while an operation is queued.
    // A result must be presented STEPS edges after its accepting edge and must stay
    // there until the consumer takes it.
    initial begin
        exp_t e;
        logic has;
        logic ev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                has = (exp_q.size() != 0);
                ev  = 1'b0;
                if (has) begin
                    ev = ((cyc - exp_q[0].acc) >= STEPS);
                end
                chk("in_ready", 64'(bus.in_ready), 64'(!has));
                chk("busy", 64'(busy), 64'(has));
                chk("out_valid", 64'(bus.out_valid), 64'(ev));
                if (ev) begin
                    chk("out_q", bus.out_q, exp_q[0].q);
                    chk("out_r", 64'(bus.out_r), 64'(exp_q[0].r));
                end
                if (abort) begin
                    exp_q.delete();
                end else if (ev && bus.out_ready) begin
                    void'(exp_q.pop_front());
                end else if (!has && bus.in_valid) begin
                    e.q   = bus.in_x / 64'(DIVISOR);
                    e.r   = RW'(bus.in_x % 64'(DIVISOR));
                    e.acc = cyc + 1;
                    exp_q.push_back(e);
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] pick_x();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = {WIDTH{1'b0}};
            1:       v = {WIDTH{1'b1}};
            2:       v = 64'(DIVISOR - 1);
            3:       v = 64'(DIVISOR);
            4:       v = {{WIDTH-32{1'b0}}, 32'($urandom)};
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    // Offer x; return at posedge+1 just after the accepting edge.
    task automatic do_op(input logic [WIDTH-1:0] x);
        bit done;
        done         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready && !abort) begin
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_x     = {32'($urandom), 32'($urandom)};
        chk("accept_timeout", 64'(done), 64'(1'b1));
    endtask

    // Wait, with a bound, until the scoreboard is empty and the unit is idle.
    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.in_ready) begin
                idle = 1'b1;
            end
        end
        chk("drain_timeout", 64'(idle), 64'(1'b1));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1'b1));
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1'b0));
        chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
        chk({tag, "_out_q"}, bus.out_q, {WIDTH{1'b0}});
        chk({tag, "_out_r"}, 64'(bus.out_r), 64'(1'b0));
    endtask

    // Stimulus: directed scenarios first, then randomized traffic with random gaps and aborts.
    initial begin
        bit seen;
        rst_n         = 1'b0;
        abort         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = {WIDTH{1'b0}};
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero and all-ones dividends.
        do_op({WIDTH{1'b0}});
        wait_idle();
        do_op({WIDTH{1'b1}});
        wait_idle();

        // Consumer stall: the result must be held and no new dividend accepted.
        bus.out_ready = 1'b0;
        do_op(64'd123456789);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        chk("stall_valid_timeout", 64'(seen), 64'(1'b1));
        bus.in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("stall_q", bus.out_q, 64'd24691357);
            chk("stall_r", 64'(bus.out_r), 64'd4);
            chk("stall_in_ready", 64'(bus.in_ready), 64'(1'b0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'(1'b1));
        chk("release_out_valid", 64'(bus.out_valid), 64'(1'b0));
        wait_idle();

        // Abort partway through the iteration.
        do_op(64'hDEAD_BEEF_0123_4567);
        repeat (6) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_in_ready", 64'(bus.in_ready), 64'(1'b1));
        chk("abort_out_valid", 64'(bus.out_valid), 64'(1'b0));
        chk("abort_busy", 64'(busy), 64'(1'b0));
        repeat (20) @(posedge clk);
        #1;
        do_op(64'd987654321);
        wait_idle();

        // Asynchronous reset in the middle of an operation.
        do_op(64'hFEDC_BA98_7654_3210);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midop_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(64'd1000000007);
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 20000; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            abort         = ($urandom_range(0, 399) == 0);
            bus.in_valid  = ($urandom_range(0, 2) == 0);
            bus.in_x      = pick_x();
            @(posedge clk);
            #1;
        end
        abort         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
